ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 59 +++++
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Shared-RAM arbiter bus: two requester ports (CPU data port and serial
// loader), the single DATA_RAM port and the current-owner indication.
// The arbiter connects through the slave modport; the environment that
// drives the requests and models the RAM connects through the master modport.
interface ram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    // CPU requester
    logic              cpu_req;
    logic              cpu_we;
    logic [SEL_W-1:0]  cpu_sel;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    // Serial-loader requester
    logic              ser_req;
    logic              ser_we;
    logic [SEL_W-1:0]  ser_sel;
    logic [ADDR_W-1:0] ser_addr;
    logic [DATA_W-1:0] ser_wdata;
    logic [DATA_W-1:0] ser_rdata;
    logic              ser_ack;

    // Shared RAM port
    logic              ram_ce;
    logic              ram_we;
    logic [SEL_W-1:0]  ram_sel;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Current grant: 00 none, 01 CPU, 10 serial
    logic [1:0]        owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_sel, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  ser_req, ser_we, ser_sel, ser_addr, ser_wdata,
        output ser_rdata, ser_ack,
        output ram_ce, ram_we, ram_sel, ram_addr, ram_wdata,
        input  ram_rdata,
        output owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_sel, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output ser_req, ser_we, ser_sel, ser_addr, ser_wdata,
        input  ser_rdata, ser_ack,
        input  ram_ce, ram_we, ram_sel, ram_addr, ram_wdata,
        output ram_rdata,
        input  owner
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port DATA_RAM. Each access is one
// grant cycle (ram_ce high) followed by a one-cycle ack carrying the
// registered read data. The CPU has priority, but after STARVE_MAX
// consecutive CPU grants taken while the serial loader waits, the serial
// loader wins the next decision.
module ram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    // Encoding chosen so the state value doubles as the owner code
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        G_CPU = 2'b01,
        G_SER = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [CNT_W-1:0]  starve_cnt;

    logic              lat_we;
    logic [SEL_W-1:0]  lat_sel;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              cpu_ack;
    logic              ser_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] ser_rdata;

    logic              cpu_elig;
    logic              ser_elig;
    logic              ser_first;
    logic              grant_cpu;
    logic              grant_ser;

    // A requester whose ack is high this cycle is still holding its old req
    assign cpu_elig  = bus.cpu_req & ~cpu_ack;
    assign ser_elig  = bus.ser_req & ~ser_ack;
    assign ser_first = (starve_cnt == CNT_MAX);

    // Grant decision and next state. The ack cycle is a turnaround with no
    // grant at all, so a CPU that keeps re-requesting and a waiting serial
    // loader compete together in the following IDLE cycle and the
    // starvation count decides between them.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch
        state_next = state;
        grant_cpu  = 1'b0;
        grant_ser  = 1'b0;
        case (state)
            IDLE: begin
                if (!cpu_ack && !ser_ack) begin
                    if (ser_elig && (ser_first || !cpu_elig)) begin
                        grant_ser  = 1'b1;
                        state_next = G_SER;
                    end else if (cpu_elig) begin
                        grant_cpu  = 1'b1;
                        state_next = G_CPU;
                    end
                end
            end
            G_CPU, G_SER: state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture the winner's access fields on the grant edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_sel   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant_cpu) begin
            lat_we    <= bus.cpu_we;
            lat_sel   <= bus.cpu_sel;
            lat_addr  <= bus.cpu_addr;
            lat_wdata <= bus.cpu_wdata;
        end else if (grant_ser) begin
            lat_we    <= bus.ser_we;
            lat_sel   <= bus.ser_sel;
            lat_addr  <= bus.ser_addr;
            lat_wdata <= bus.ser_wdata;
        end
    end

    // Completion: register RAM read data and pulse the owner's ack once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ack   <= 1'b0;
            ser_ack   <= 1'b0;
            cpu_rdata <= '0;
            ser_rdata <= '0;
        end else begin
            cpu_ack <= (state == G_CPU);
            ser_ack <= (state == G_SER);
            if (state == G_CPU) cpu_rdata <= bus.ram_rdata;
            if (state == G_SER) ser_rdata <= bus.ram_rdata;
        end
    end

    // Consecutive CPU grants taken while serial waits, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.ser_req || grant_ser) begin
            starve_cnt <= '0;
        end else if (grant_cpu && ser_elig && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Drive the shared RAM port from the latched fields only while granted;
    // being decoded from state, ram_ce drops the instant reset is applied
    always_comb begin
        bus.ram_ce    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_sel   = '0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.owner     = 2'b00;
        if (state == G_CPU || state == G_SER) begin
            bus.ram_ce    = 1'b1;
            bus.ram_we    = lat_we;
            bus.ram_sel   = lat_sel;
            bus.ram_addr  = lat_addr;
            bus.ram_wdata = lat_wdata;
            bus.owner     = {state == G_SER, state == G_CPU};
        end
    end

    assign bus.cpu_ack   = cpu_ack;
    assign bus.ser_ack   = ser_ack;
    assign bus.cpu_rdata = cpu_rdata;
    assign bus.ser_rdata = ser_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed cycle table, hand-written starvation and
// reset-abort sequences, then randomized traffic from two well-behaved
// requesters checked against a transaction-level memory model.
module tb_ram_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int RAND_CYC   = 3000;
    localparam int WAIT_MAX   = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Word-addressed RAM with combinational read and byte-enabled write
    logic [31:0] mem [0:255];
    assign bus.ram_rdata = mem[bus.ram_addr[7:0]];
    always @(posedge clk)
        if (bus.ram_ce && bus.ram_we)
            mem[bus.ram_addr[7:0]] <= merge(mem[bus.ram_addr[7:0]], bus.ram_wdata, bus.ram_sel);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_sel = 4'hF;
        bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        bus.ser_req = 1'b0; bus.ser_we = 1'b0; bus.ser_sel = 4'hF;
        bus.ser_addr = '0;  bus.ser_wdata = '0;
    endtask

    // One row = inputs applied for a cycle plus outputs expected in that cycle
    typedef struct {
        logic        c_req, c_we;
        logic [7:0]  c_addr;
        logic [31:0] c_wdata;
        logic        s_req, s_we;
        logic [7:0]  s_addr;
        logic [31:0] s_wdata;
        logic [1:0]  owner;
        logic        ce, rwe;
        logic [7:0]  raddr;
        logic        cack, sack;
        logic        chk_c;
        logic [31:0] cdata;
        logic        chk_s;
        logic [31:0] sdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(
        input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
        input logic sr, input logic sw, input logic [7:0] sa, input logic [31:0] sd,
        input logic [1:0] ow, input logic ce, input logic rwe, input logic [7:0] ra,
        input logic cak, input logic sak,
        input logic kc, input logic [31:0] ec, input logic ks, input logic [31:0] es);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
        v.s_req = sr; v.s_we = sw; v.s_addr = sa; v.s_wdata = sd;
        v.owner = ow; v.ce = ce; v.rwe = rwe; v.raddr = ra;
        v.cack = cak; v.sack = sak;
        v.chk_c = kc; v.cdata = ec; v.chk_s = ks; v.sdata = es;
        return v;
    endfunction

    // Random-phase requester state, index 0 = CPU, 1 = serial
    int          pend [2];
    int          wt   [2];
    int          gap  [2];
    logic        r_we   [2];
    logic [3:0]  r_sel  [2];
    logic [7:0]  r_addr [2];
    logic [31:0] r_wd   [2];
    logic [31:0] ref_mem [0:255];
    logic [1:0]  ack_v;
    logic [31:0] rd_v [2];
    int          cpu_during_ser;
    int          grants;
    int          cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        #1;
        mem[8'h10] <= 32'hDEADBEEF;
        mem[8'h30] <= 32'h0BADF00D;
        rst = 1'b1;
        #2;
        // Reset values, before any clock edge
        check("reset owner",     32'(bus.owner), 0);
        check("reset ram_ce",    32'(bus.ram_ce), 0);
        check("reset ram_addr",  bus.ram_addr, 0);
        check("reset cpu_ack",   32'(bus.cpu_ack), 0);
        check("reset ser_ack",   32'(bus.ser_ack), 0);
        check("reset cpu_rdata", bus.cpu_rdata, 0);
        check("reset starve",    32'(dut.starve_cnt), 0);
        #15 rst = 1'b0;
        tick();

        // Directed cycle table
        //           c: req we addr  wdata          s: req we addr  wdata         own ce we raddr ca sa kc cdata         ks sdata
        vecs.push_back(row(1,0,8'h10,0,             0,0,0,0,                      2'd0,0,0,8'h00, 0,0, 0,0,            0,0));
        vecs.push_back(row(1,0,8'h10,0,             0,0,0,0,                      2'd1,1,0,8'h10, 0,0, 0,0,            0,0));
        vecs.push_back(row(1,0,8'h10,0,             0,0,0,0,                      2'd0,0,0,8'h00, 1,0, 1,32'hDEADBEEF, 0,0));
        vecs.push_back(row(0,0,0,0,                 0,0,0,0,                      2'd0,0,0,8'h00, 0,0, 0,0,            0,0));
        vecs.push_back(row(0,0,0,0,                 1,1,8'h20,32'h12345678,       2'd0,0,0,8'h00, 0,0, 0,0,            0,0));
        vecs.push_back(row(0,0,0,0,                 1,1,8'h20,32'h12345678,       2'd2,1,1,8'h20, 0,0, 0,0,            0,0));
        vecs.push_back(row(1,0,8'h20,0,             0,0,0,0,                      2'd0,0,0,8'h00, 0,1, 0,0,            0,0));
        vecs.push_back(row(1,0,8'h20,0,             0,0,0,0,                      2'd0,0,0,8'h00, 0,0, 0,0,            0,0));
        vecs.push_back(row(0,0,0,0,                 0,0,0,0,                      2'd1,1,0,8'h20, 0,0, 0,0,            0,0));
        vecs.push_back(row(0,0,0,0,                 0,0,0,0,                      2'd0,0,0,8'h00, 1,0, 1,32'h12345678, 0,0));
        vecs.push_back(row(1,0,8'h10,0,             1,0,8'h20,0,                  2'd0,0,0,8'h00, 0,0, 0,0,            0,0));
        vecs.push_back(row(1,0,8'h10,0,             1,0,8'h20,0,                  2'd1,1,0,8'h10, 0,0, 0,0,            0,0));
        vecs.push_back(row(0,0,0,0,                 1,0,8'h20,0,                  2'd0,0,0,8'h00, 1,0, 1,32'hDEADBEEF, 0,0));
        vecs.push_back(row(0,0,0,0,                 1,0,8'h20,0,                  2'd0,0,0,8'h00, 0,0, 0,0,            0,0));
        vecs.push_back(row(0,0,0,0,                 1,0,8'h20,0,                  2'd2,1,0,8'h20, 0,0, 0,0,            0,0));
        vecs.push_back(row(0,0,0,0,                 0,0,0,0,                      2'd0,0,0,8'h00, 0,1, 0,0,            1,32'h12345678));
        vecs.push_back(row(0,0,0,0,                 0,0,0,0,                      2'd0,0,0,8'h00, 0,0, 0,0,            0,0));
        vecs.push_back(row(1,0,8'h10,0,             0,0,0,0,                      2'd0,0,0,8'h00, 0,0, 0,0,            0,0));
        vecs.push_back(row(1,0,8'h10,0,             1,0,8'h20,0,                  2'd1,1,0,8'h10, 0,0, 0,0,            0,0));
        vecs.push_back(row(0,0,0,0,                 0,0,0,0,                      2'd0,0,0,8'h00, 1,0, 1,32'hDEADBEEF, 0,0));
        vecs.push_back(row(0,0,0,0,                 0,0,0,0,                      2'd0,0,0,8'h00, 0,0, 0,0,            0,0));
        vecs.push_back(row(0,0,0,0,                 0,0,0,0,                      2'd0,0,0,8'h00, 0,0, 0,0,            0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            bus.cpu_req = vecs[i].c_req; bus.cpu_we = vecs[i].c_we;
            bus.cpu_addr = 32'(vecs[i].c_addr); bus.cpu_wdata = vecs[i].c_wdata;
            bus.ser_req = vecs[i].s_req; bus.ser_we = vecs[i].s_we;
            bus.ser_addr = 32'(vecs[i].s_addr); bus.ser_wdata = vecs[i].s_wdata;
            #2;
            check($sformatf("row%0d owner", i),    32'(bus.owner),   32'(vecs[i].owner));
            check($sformatf("row%0d ram_ce", i),   32'(bus.ram_ce),  32'(vecs[i].ce));
            check($sformatf("row%0d ram_we", i),   32'(bus.ram_we),  32'(vecs[i].rwe));
            check($sformatf("row%0d ram_addr", i), bus.ram_addr,     32'(vecs[i].raddr));
            check($sformatf("row%0d cpu_ack", i),  32'(bus.cpu_ack), 32'(vecs[i].cack));
            check($sformatf("row%0d ser_ack", i),  32'(bus.ser_ack), 32'(vecs[i].sack));
            if (vecs[i].chk_c) check($sformatf("row%0d cpu_rdata", i), bus.cpu_rdata, vecs[i].cdata);
            if (vecs[i].chk_s) check($sformatf("row%0d ser_rdata", i), bus.ser_rdata, vecs[i].sdata);
            @(posedge clk);
            #1;
        end

        // Starvation: CPU keeps requesting, serial waits; 5th grant is serial
        idle_inputs();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
        bus.ser_req = 1'b1; bus.ser_addr = 32'h20;
        grants = 0;
        cyc = 0;
        while (grants < 5 && cyc < 40) begin
            tick();
            cyc++;
            if (bus.owner != 2'b00) begin
                grants++;
                check($sformatf("starve grant%0d owner", grants), 32'(bus.owner), (grants < 5) ? 1 : 2);
                if (grants == 4) check("starve count at 4th grant", 32'(dut.starve_cnt), STARVE_MAX);
                if (grants == 5) begin
                    check("starve count after serial grant", 32'(dut.starve_cnt), 0);
                    bus.cpu_req = 1'b0;
                    bus.ser_req = 1'b0;
                end
            end
        end
        check("starve grants reached", grants, 5);
        tick();
        check("starve ser_ack", 32'(bus.ser_ack), 1);
        repeat (3) tick();
        check("starve count idle", 32'(dut.starve_cnt), 0);

        // Reset during the grant cycle of a CPU write aborts it
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_sel = 4'hF;
        bus.cpu_addr = 32'h30; bus.cpu_wdata = 32'hAAAA5555;
        tick();
        check("abort pre ram_ce", 32'(bus.ram_ce), 1);
        #2 rst = 1'b1;
        #1;
        check("abort ram_ce",    32'(bus.ram_ce), 0);
        check("abort ram_we",    32'(bus.ram_we), 0);
        check("abort owner",     32'(bus.owner), 0);
        check("abort ram_wdata", bus.ram_wdata, 0);
        check("abort cpu_rdata", bus.cpu_rdata, 0);
        tick();
        check("in-reset no grant", 32'(bus.owner), 0);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("abort no ack %0d", k), 32'(bus.cpu_ack), 0);
        end
        check("abort RAM unchanged", mem[8'h30], 32'h0BADF00D);

        // Randomized traffic against a transaction-level memory model
        idle_inputs();
        for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; wt[i] = 0; gap[i] = 0;
            r_we[i] = 1'b0; r_sel[i] = 4'h0; r_addr[i] = 8'h0; r_wd[i] = 32'h0;
        end
        cpu_during_ser = 0;
        for (int c = 0; c < RAND_CYC + 60; c++) begin
            ack_v   = {bus.ser_ack, bus.cpu_ack};
            rd_v[0] = bus.cpu_rdata;
            rd_v[1] = bus.ser_rdata;
            for (int i = 0; i < 2; i++) begin
                if (ack_v[i]) begin
                    if (pend[i] == 0) begin
                        check($sformatf("rand spurious ack%0d", i), 1, 0);
                    end else begin
                        if (!r_we[i])
                            check($sformatf("rand rdata%0d @%h", i, r_addr[i]), rd_v[i], ref_mem[r_addr[i]]);
                        else
                            ref_mem[r_addr[i]] = merge(ref_mem[r_addr[i]], r_wd[i], r_sel[i]);
                        if (i == 1) begin
                            check("rand serial starvation bound", 32'(cpu_during_ser <= STARVE_MAX + 1), 1);
                            cpu_during_ser = 0;
                        end else if (pend[1] != 0) begin
                            cpu_during_ser++;
                        end
                        pend[i] = 0;
                        gap[i]  = $urandom_range(1, 3);
                    end
                end else if (pend[i] != 0) begin
                    wt[i]++;
                    if (wt[i] > WAIT_MAX) begin
                        check($sformatf("rand ack timeout%0d", i), 32'(wt[i]), WAIT_MAX);
                        pend[i] = 0;
                        gap[i]  = 1;
                    end
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end else if (c < RAND_CYC && $urandom_range(0, 1) == 1) begin
                    pend[i]   = 1;
                    wt[i]     = 0;
                    r_we[i]   = 1'($urandom_range(0, 1));
                    r_sel[i]  = 4'($urandom_range(1, 15));
                    r_addr[i] = 8'h40 + 8'($urandom_range(0, 7));
                    r_wd[i]   = $urandom;
                    if (i == 1) cpu_during_ser = 0;
                end
            end
            bus.cpu_req = (pend[0] != 0); bus.cpu_we = r_we[0]; bus.cpu_sel = r_sel[0];
            bus.cpu_addr = 32'(r_addr[0]); bus.cpu_wdata = r_wd[0];
            bus.ser_req = (pend[1] != 0); bus.ser_we = r_we[1]; bus.ser_sel = r_sel[1];
            bus.ser_addr = 32'(r_addr[1]); bus.ser_wdata = r_wd[1];
            tick();
        end
        check("rand cpu drained", 32'(pend[0]), 0);
        check("rand ser drained", 32'(pend[1]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
